btn_count_ctrl: RTL and testbench

Front-end controller for the 2-bit button counter FSM. It takes a raw, asynchronous, bouncy push-button and drives the counter's `cnt` input.
- Synchronises and debounces the button.
- Emits exactly one single-cycle `cnt` pulse per clean press.
- Optionally auto-repeats while the button is held.
- Gates pulses with an enable so the counter is only stepped when allowed.

---
 rtl/btn_count_ctrl.sv | 141 ++++++++++++++
 tb/tb_btn_count_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_count_ctrl.sv
// Button front-end for the 2-bit counter: synchronise, debounce,
// one step pulse per press, optional auto-repeat, enable gating.
module btn_count_ctrl #(
   parameter int DB_CYCLES     = 4,
   parameter int HOLD_CYCLES   = 16,
   parameter int REPEAT_CYCLES = 8,
   parameter int CW            = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_raw,
   input  logic       en,
   input  logic       rpt_en,
   output logic       cnt,
   output logic       held,
   output logic [2:0] state
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] DEB_PRS = 3'd1;
   localparam logic [2:0] PRESSED = 3'd2;
   localparam logic [2:0] REPEAT  = 3'd3;
   localparam logic [2:0] DEB_REL = 3'd4;

   localparam logic [CW-1:0] DB_MAX   = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REP_MAX  = CW'(REPEAT_CYCLES - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   logic          sync1;
   logic          btn_s;
   logic [CW-1:0] c;
   logic [CW-1:0] c_nxt;
   logic [2:0]    state_nxt;
   logic          fire;
   logic          held_nxt;

   // Two-flop synchroniser for the asynchronous button level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         btn_s <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         btn_s <= sync1;
      end
   end

   // Next-state, shared counter and step-event decode.
   always_comb begin
      state_nxt = state;
      c_nxt     = c;
      fire      = 1'b0;
      case (state)
         IDLE: begin
            c_nxt = '0;
            if (btn_s) begin
               state_nxt = DEB_PRS;
            end
         end
         DEB_PRS: begin
            if (!btn_s) begin
               state_nxt = IDLE;
               c_nxt     = '0;
            end else if (c == DB_MAX) begin
               state_nxt = PRESSED;
               c_nxt     = '0;
               fire      = 1'b1;
            end else begin
               c_nxt = c + ONE;
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_nxt = DEB_REL;
               c_nxt     = '0;
            end else if (c == HOLD_MAX) begin
               if (rpt_en) begin
                  state_nxt = REPEAT;
                  c_nxt     = '0;
                  fire      = 1'b1;
               end
            end else begin
               c_nxt = c + ONE;
            end
         end
         REPEAT: begin
            if (!btn_s) begin
               state_nxt = DEB_REL;
               c_nxt     = '0;
            end else if (!rpt_en) begin
               state_nxt = PRESSED;
               c_nxt     = HOLD_MAX;
            end else if (c == REP_MAX) begin
               c_nxt = '0;
               fire  = 1'b1;
            end else begin
               c_nxt = c + ONE;
            end
         end
         DEB_REL: begin
            if (btn_s) begin
               state_nxt = PRESSED;
               c_nxt     = '0;
            end else if (c == DB_MAX) begin
               state_nxt = IDLE;
               c_nxt     = '0;
            end else begin
               c_nxt = c + ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            c_nxt     = '0;
         end
      endcase
   end

   // Held flag follows the state being entered.
   always_comb begin
      held_nxt = (state_nxt == PRESSED) ||
                 (state_nxt == REPEAT)  ||
                 (state_nxt == DEB_REL);
   end

   // State, counter and registered outputs; pulses gated by en.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         c     <= '0;
         cnt   <= 1'b0;
         held  <= 1'b0;
      end else begin
         state <= state_nxt;
         c     <= c_nxt;
         cnt   <= fire & en;
         held  <= held_nxt;
      end
   end

endmodule

// File: tb/tb_btn_count_ctrl.sv
// Bench for btn_count_ctrl: expected pulse edges are queued as stimulus
// is applied and matched against cnt as pulses appear.
module tb_btn_count_ctrl;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_raw;
   logic       en;
   logic       rpt_en;
   logic       cnt;
   logic       held;
   logic [2:0] state;

   typedef struct {
      int         e;
      logic [1:0] ctr;
   } exp_t;

   exp_t       q[$];
   exp_t       ex;
   int         edge_n = 0;
   int         vectors = 0;
   int         miscompares = 0;
   logic [1:0] dn_ctr;
   logic       prev_cnt = 1'b0;

   btn_count_ctrl #(
      .DB_CYCLES(DB),
      .HOLD_CYCLES(16),
      .REPEAT_CYCLES(8),
      .CW(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_raw(btn_raw),
      .en(en),
      .rpt_en(rpt_en),
      .cnt(cnt),
      .held(held),
      .state(state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Downstream 2-bit counter stepped by cnt.
   always @(posedge clk) begin
      if (rst) dn_ctr <= 2'd0;
      else if (cnt === 1'b1) dn_ctr <= dn_ctr + 2'd1;
   end

   // Pulse monitor: every observed pulse must match the queue head.
   always @(negedge clk) begin
      if (cnt === 1'b1) begin
         vectors++;
         if (prev_cnt) begin
            miscompares++;
            $display("FAIL cnt_back_to_back edge=%0d", edge_n);
         end
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL pulse_unexpected got edge=%0d exp none", edge_n);
         end else begin
            ex = q.pop_front();
            if (edge_n !== ex.e || dn_ctr !== ex.ctr) begin
               miscompares++;
               $display("FAIL pulse got edge=%0d ctr=%0d exp edge=%0d ctr=%0d",
                        edge_n, dn_ctr, ex.e, ex.ctr);
            end
         end
      end
      prev_cnt = (cnt === 1'b1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic at_edge(input int e);
      while (edge_n < e) tick(1);
   endtask

   task automatic push(input int e, input logic [1:0] ctr);
      exp_t x;
      x.e   = e;
      x.ctr = ctr;
      q.push_back(x);
   endtask

   task automatic drained(input string name);
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL %s missing_pulses got=%0d exp=0", name, q.size());
      end
      q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; btn_raw = 1'b0; en = 1'b1; rpt_en = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_raw = 1'b0; en = 1'b1; rpt_en = 1'b0;
      tick(1);
      vectors++;
      if (state !== 3'd0) begin miscompares++; $display("FAIL rst_state got=%0d exp=0", state); end
      vectors++;
      if (cnt !== 1'b0) begin miscompares++; $display("FAIL rst_cnt got=%0b exp=0", cnt); end
      vectors++;
      if (held !== 1'b0) begin miscompares++; $display("FAIL rst_held got=%0b exp=0", held); end
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_single_press();
      int e0;
      do_reset();
      e0 = edge_n;
      btn_raw = 1'b1;
      push(e0 + 1 + 2 + DB, 2'd0);
      at_edge(e0 + 6);
      vectors++;
      if (state !== 3'd1 || held !== 1'b0) begin
         miscompares++; $display("FAIL press_deb got=%0d/%0b exp=1/0", state, held);
      end
      at_edge(e0 + 7);
      vectors++;
      if (state !== 3'd2 || held !== 1'b1) begin
         miscompares++; $display("FAIL press_enter got=%0d/%0b exp=2/1", state, held);
      end
      at_edge(e0 + 12);
      btn_raw = 1'b0;
      at_edge(e0 + 15);
      vectors++;
      if (state !== 3'd4) begin miscompares++; $display("FAIL rel_deb got=%0d exp=4", state); end
      at_edge(e0 + 18);
      vectors++;
      if (state !== 3'd4 || held !== 1'b1) begin
         miscompares++; $display("FAIL rel_hold got=%0d/%0b exp=4/1", state, held);
      end
      at_edge(e0 + 19);
      vectors++;
      if (state !== 3'd0 || held !== 1'b0) begin
         miscompares++; $display("FAIL rel_idle got=%0d/%0b exp=0/0", state, held);
      end
      drained("single_press");
   endtask

   task automatic test_bounce();
      logic seen1;
      logic seenh;
      do_reset();
      seen1 = 1'b0;
      seenh = 1'b0;
      for (int r = 0; r < 5; r++) begin
         for (int j = 0; j < 3; j++) begin
            btn_raw = (j < 2);
            tick(1);
            if (state === 3'd1) seen1 = 1'b1;
            if (held !== 1'b0) seenh = 1'b1;
         end
      end
      btn_raw = 1'b0;
      tick(8);
      vectors++;
      if (seen1 !== 1'b1) begin miscompares++; $display("FAIL bounce_visit got=%0b exp=1", seen1); end
      vectors++;
      if (seenh !== 1'b0) begin miscompares++; $display("FAIL bounce_held got=%0b exp=0", seenh); end
      vectors++;
      if (state !== 3'd0) begin miscompares++; $display("FAIL bounce_idle got=%0d exp=0", state); end
      drained("bounce");
   endtask

   task automatic test_repeat();
      int p;
      do_reset();
      rpt_en = 1'b1;
      p = edge_n + 7;
      btn_raw = 1'b1;
      push(p, 2'd0);
      push(p + 16, 2'd1);
      push(p + 24, 2'd2);
      push(p + 32, 2'd3);
      push(p + 40, 2'd0);
      at_edge(p + 20);
      vectors++;
      if (state !== 3'd3) begin miscompares++; $display("FAIL rpt_state got=%0d exp=3", state); end
      at_edge(p + 40);
      btn_raw = 1'b0;
      at_edge(p + 48);
      vectors++;
      if (state !== 3'd0) begin miscompares++; $display("FAIL rpt_idle got=%0d exp=0", state); end
      vectors++;
      if (dn_ctr !== 2'd1) begin miscompares++; $display("FAIL rpt_ctr got=%0d exp=1", dn_ctr); end
      drained("repeat");
   endtask

   task automatic test_enable();
      int p;
      do_reset();
      rpt_en = 1'b1;
      en = 1'b0;
      p = edge_n + 7;
      btn_raw = 1'b1;
      push(p + 16, 2'd0);
      push(p + 24, 2'd1);
      at_edge(p + 9);
      en = 1'b1;
      at_edge(p + 26);
      vectors++;
      if (held !== 1'b1) begin miscompares++; $display("FAIL en_held got=%0b exp=1", held); end
      btn_raw = 1'b0;
      at_edge(p + 34);
      vectors++;
      if (state !== 3'd0) begin miscompares++; $display("FAIL en_idle got=%0d exp=0", state); end
      drained("enable");
   endtask

   task automatic test_glitch();
      int p;
      do_reset();
      p = edge_n + 7;
      btn_raw = 1'b1;
      push(p, 2'd0);
      at_edge(p + 3);
      btn_raw = 1'b0;
      at_edge(p + 5);
      btn_raw = 1'b1;
      at_edge(p + 6);
      vectors++;
      if (state !== 3'd4) begin miscompares++; $display("FAIL glitch_rel got=%0d exp=4", state); end
      at_edge(p + 8);
      vectors++;
      if (state !== 3'd2 || held !== 1'b1) begin
         miscompares++; $display("FAIL glitch_back got=%0d/%0b exp=2/1", state, held);
      end
      at_edge(p + 20);
      btn_raw = 1'b0;
      at_edge(p + 28);
      vectors++;
      if (state !== 3'd0) begin miscompares++; $display("FAIL glitch_idle got=%0d exp=0", state); end
      drained("glitch");
   endtask

   task automatic test_mid_reset();
      int p;
      int r;
      do_reset();
      rpt_en = 1'b1;
      p = edge_n + 7;
      btn_raw = 1'b1;
      push(p, 2'd0);
      push(p + 16, 2'd1);
      at_edge(p + 20);
      vectors++;
      if (state !== 3'd3) begin miscompares++; $display("FAIL mr_pre got=%0d exp=3", state); end
      rst = 1'b1;
      r = p + 21;
      at_edge(r);
      vectors++;
      if (state !== 3'd0 || cnt !== 1'b0 || held !== 1'b0) begin
         miscompares++;
         $display("FAIL mr_abort got=%0d/%0b/%0b exp=0/0/0", state, cnt, held);
      end
      rst = 1'b0;
      push(r + 1 + 2 + DB, 2'd0);
      at_edge(r + 8);
      vectors++;
      if (state !== 3'd2 || held !== 1'b1) begin
         miscompares++; $display("FAIL mr_repress got=%0d/%0b exp=2/1", state, held);
      end
      btn_raw = 1'b0;
      at_edge(r + 16);
      vectors++;
      if (state !== 3'd0) begin miscompares++; $display("FAIL mr_idle got=%0d exp=0", state); end
      drained("mid_reset");
   endtask

   initial begin
      rst = 1'b1; btn_raw = 1'b0; en = 1'b1; rpt_en = 1'b0;
      test_reset();
      test_single_press();
      test_bounce();
      test_repeat();
      test_enable();
      test_glitch();
      test_mid_reset();
      tick(3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
